// File: rtl/egress_arbiter.sv
// rtl/egress_arbiter.sv - round-robin frame-atomic arbiter for one egress port
// Claims frames whose tdest matches PORT_ID; a watchdog ends frames whose source stalls.
module egress_arbiter #(
   parameter int         NUM_INGRESS    = 4,
   parameter logic [1:0] PORT_ID        = 2'd0,
   parameter int         TIMEOUT_CYCLES = 64
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           en,
   input  logic [NUM_INGRESS-1:0]         ingress_source_tvalid,
   input  logic [NUM_INGRESS*16-1:0]      ingress_source_tdata,
   input  logic [NUM_INGRESS*2-1:0]       ingress_source_tdest,
   input  logic [NUM_INGRESS-1:0]         ingress_source_tlast,
   output logic [NUM_INGRESS-1:0]         ingress_sink_tready,
   output logic                           egress_source_tvalid,
   output logic [15:0]                    egress_source_tdata,
   output logic                           egress_source_tlast,
   input  logic                           egress_sink_tready,
   output logic [$clog2(NUM_INGRESS)-1:0] grant_id,
   output logic                           busy,
   output logic [15:0]                    frame_count,
   output logic [7:0]                     abort_count
);

   localparam int GW = $clog2(NUM_INGRESS);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_BUSY  = 2'd1;
   localparam logic [1:0] S_ABORT = 2'd2;

   logic [1:0]             state;
   logic [GW-1:0]          rr_ptr;
   logic [CW-1:0]          idle_cnt;
   logic [NUM_INGRESS-1:0] req;
   logic                   pick_valid;
   logic [GW-1:0]          pick_idx;
   logic [GW:0]            scan;
   logic                   sel_tvalid;
   logic [15:0]            sel_tdata;
   logic                   sel_tlast;
   logic [GW-1:0]          next_rr;

   always_comb begin
      req = '0;
      for (int i = 0; i < NUM_INGRESS; i++) begin
         req[i] = ingress_source_tvalid[i] && (ingress_source_tdest[i*2 +: 2] == PORT_ID);
      end
   end

   // Scan from the farthest offset down so the request nearest rr_ptr is the one kept.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      scan       = '0;
      for (int k = NUM_INGRESS - 1; k >= 0; k--) begin
         scan = {1'b0, rr_ptr} + (GW+1)'(k);
         if (scan >= (GW+1)'(NUM_INGRESS)) begin
            scan = scan - (GW+1)'(NUM_INGRESS);
         end
         if (req[scan[GW-1:0]]) begin
            pick_valid = 1'b1;
            pick_idx   = scan[GW-1:0];
         end
      end
   end

   assign sel_tvalid = ingress_source_tvalid[grant_id];
   assign sel_tdata  = ingress_source_tdata[int'(grant_id)*16 +: 16];
   assign sel_tlast  = ingress_source_tlast[grant_id];
   assign next_rr    = (grant_id == GW'(NUM_INGRESS - 1)) ? '0 : grant_id + GW'(1);
   assign busy       = (state != S_IDLE);

   always_comb begin
      egress_source_tvalid = 1'b0;
      egress_source_tdata  = 16'h0000;
      egress_source_tlast  = 1'b0;
      ingress_sink_tready  = '0;
      case (state)
         S_BUSY: begin
            egress_source_tvalid          = sel_tvalid;
            egress_source_tdata           = sel_tdata;
            egress_source_tlast           = sel_tlast;
            ingress_sink_tready[grant_id] = egress_sink_tready;
         end
         S_ABORT: begin
            egress_source_tvalid = 1'b1;
            egress_source_tlast  = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         rr_ptr      <= '0;
         grant_id    <= '0;
         idle_cnt    <= '0;
         frame_count <= '0;
         abort_count <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (en && pick_valid) begin
                  grant_id <= pick_idx;
                  idle_cnt <= '0;
                  state    <= S_BUSY;
               end
            end
            S_BUSY: begin
               // A present beat always clears the watchdog, so completion can never race an abort.
               if (sel_tvalid) begin
                  idle_cnt <= '0;
                  if (egress_sink_tready && sel_tlast) begin
                     frame_count <= frame_count + 16'd1;
                     rr_ptr      <= next_rr;
                     state       <= S_IDLE;
                  end
               end else if (idle_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                  idle_cnt <= CW'(TIMEOUT_CYCLES);
                  state    <= S_ABORT;
               end else begin
                  idle_cnt <= idle_cnt + CW'(1);
               end
            end
            S_ABORT: begin
               if (egress_sink_tready) begin
                  if (abort_count != 8'hFF) begin
                     abort_count <= abort_count + 8'd1;
                  end
                  rr_ptr   <= next_rr;
                  idle_cnt <= '0;
                  state    <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_egress_arbiter.sv
// tb/tb_egress_arbiter.sv - directed bench for egress_arbiter
// Sources are modelled as per-requester frame generators advanced on observed handshakes.
module tb_egress_arbiter;

   localparam int N = 4;

   logic          clk;
   logic          reset;
   logic          en;
   logic [N-1:0]  ingress_source_tvalid;
   logic [N*16-1:0] ingress_source_tdata;
   logic [N*2-1:0] ingress_source_tdest;
   logic [N-1:0]  ingress_source_tlast;
   logic [N-1:0]  ingress_sink_tready;
   logic          egress_source_tvalid;
   logic [15:0]   egress_source_tdata;
   logic          egress_source_tlast;
   logic          egress_sink_tready;
   logic [1:0]    grant_id;
   logic          busy;
   logic [15:0]   frame_count;
   logic [7:0]    abort_count;

   int total;
   int bad;

   int          len [N];
   int          bidx [N];
   int          stall_at [N];
   logic [15:0] base [N];
   logic [1:0]  dst [N];
   bit          act [N];
   bit          rep [N];
   logic [N-1:0] hs;
   logic [16:0] log_q [$];

   egress_arbiter #(.NUM_INGRESS(N), .PORT_ID(2'd0), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk),
      .reset(reset),
      .en(en),
      .ingress_source_tvalid(ingress_source_tvalid),
      .ingress_source_tdata(ingress_source_tdata),
      .ingress_source_tdest(ingress_source_tdest),
      .ingress_source_tlast(ingress_source_tlast),
      .ingress_sink_tready(ingress_sink_tready),
      .egress_source_tvalid(egress_source_tvalid),
      .egress_source_tdata(egress_source_tdata),
      .egress_source_tlast(egress_source_tlast),
      .egress_sink_tready(egress_sink_tready),
      .grant_id(grant_id),
      .busy(busy),
      .frame_count(frame_count),
      .abort_count(abort_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic src(input int i, input int l, input logic [15:0] b, input logic [1:0] d, input bit r);
      len[i] = l; bidx[i] = 0; base[i] = b; dst[i] = d; act[i] = 1'b1; rep[i] = r; stall_at[i] = 99;
   endtask

   task automatic clear_all();
      for (int i = 0; i < N; i++) begin
         act[i] = 1'b0; rep[i] = 1'b0; len[i] = 0; bidx[i] = 0; stall_at[i] = 99;
         base[i] = 16'h0; dst[i] = 2'd0;
      end
   endtask

   task automatic apply();
      for (int i = 0; i < N; i++) begin
         ingress_source_tvalid[i]       = act[i] && (bidx[i] < len[i]) && (bidx[i] < stall_at[i]);
         ingress_source_tdata[i*16 +: 16] = base[i] + 16'(bidx[i]);
         ingress_source_tdest[i*2 +: 2] = dst[i];
         ingress_source_tlast[i]        = (bidx[i] == len[i] - 1);
      end
      #1;
   endtask

   // Sample handshakes mid-cycle, cross the edge, advance sources, re-drive.
   task automatic step();
      hs = ingress_sink_tready & ingress_source_tvalid;
      if (egress_source_tvalid && egress_sink_tready) log_q.push_back({egress_source_tlast, egress_source_tdata});
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (hs[i]) begin
            bidx[i]++;
            if (bidx[i] == len[i]) begin
               if (rep[i]) begin
                  bidx[i] = 0;
                  base[i] = base[i] + 16'h0010;
               end else begin
                  act[i] = 1'b0;
               end
            end
         end
      end
      apply();
   endtask

   initial begin
      total = 0;
      bad = 0;
      reset = 1'b1;
      en = 1'b1;
      egress_sink_tready = 1'b1;
      clear_all();
      apply();
      repeat (2) @(posedge clk);
      #2;
      check("rst_tvalid", egress_source_tvalid, 0);
      check("rst_tready", ingress_sink_tready, 0);
      check("rst_busy", busy, 0);
      check("rst_grant", grant_id, 0);
      check("rst_fc", frame_count, 0);
      check("rst_ac", abort_count, 0);
      reset = 1'b0;

      // single 4-beat frame from source 2
      src(2, 4, 16'hA000, 2'd0, 1'b0);
      apply();
      check("a_idle_tvalid", egress_source_tvalid, 0);
      check("a_idle_tready", ingress_sink_tready, 0);
      step();
      check("a_grant", grant_id, 2);
      check("a_busy", busy, 1);
      check("a_tready", ingress_sink_tready, 4'b0100);
      check("a_beat0", egress_source_tdata, 16'hA000);
      step();
      check("a_beat1", egress_source_tdata, 16'hA001);
      step();
      check("a_beat2", egress_source_tdata, 16'hA002);
      check("a_beat2_last", egress_source_tlast, 0);
      step();
      check("a_beat3", egress_source_tdata, 16'hA003);
      check("a_beat3_last", egress_source_tlast, 1);
      step();
      check("a_done_busy", busy, 0);
      check("a_done_tvalid", egress_source_tvalid, 0);
      check("a_fc", frame_count, 1);
      check("a_log_n", log_q.size(), 4);
      check("a_log3", log_q[3], 17'h1A003);
      log_q.delete();

      // rr_ptr now 3: with 1 and 3 requesting, 3 first then 1
      src(1, 1, 16'hB100, 2'd0, 1'b0);
      src(3, 1, 16'hB300, 2'd0, 1'b0);
      apply();
      step();
      check("rr_grant3", grant_id, 3);
      step();
      check("rr_bubble", busy, 0);
      check("rr_fc2", frame_count, 2);
      step();
      check("rr_grant1", grant_id, 1);
      step();
      check("rr_fc3", frame_count, 3);

      // fairness from reset
      reset = 1'b1;
      clear_all();
      apply();
      step();
      reset = 1'b0;
      log_q.delete();
      for (int i = 0; i < N; i++) src(i, 2, 16'h1000 * 16'(i + 1), 2'd0, 1'b1);
      apply();
      for (int f = 0; f < 5; f++) begin
         step();
         check("fair_grant", grant_id, f % 4);
         check("fair_busy", busy, 1);
         step();
         step();
         check("fair_bubble", busy, 0);
         check("fair_fc", frame_count, f + 1);
      end
      clear_all();
      apply();
      check("fair_log_n", log_q.size(), 10);
      log_q.delete();

      // filtering and backpressure; rr_ptr is 1
      src(1, 3, 16'hC100, 2'd1, 1'b0);
      src(3, 3, 16'hC300, 2'd0, 1'b0);
      apply();
      step();
      check("flt_grant", grant_id, 3);
      check("flt_tready", ingress_sink_tready, 4'b1000);
      check("flt_b0", egress_source_tdata, 16'hC300);
      step();
      egress_sink_tready = 1'b0;
      #1;
      check("flt_b1_stall", egress_source_tdata, 16'hC301);
      check("flt_tready_stall", ingress_sink_tready, 0);
      step();
      egress_sink_tready = 1'b1;
      #1;
      check("flt_b1_held", egress_source_tdata, 16'hC301);
      check("flt_tready_go", ingress_sink_tready, 4'b1000);
      step();
      egress_sink_tready = 1'b0;
      #1;
      check("flt_b2", egress_source_tdata, 16'hC302);
      check("flt_b2_last", egress_source_tlast, 1);
      step();
      egress_sink_tready = 1'b1;
      #1;
      step();
      check("flt_done", busy, 0);
      check("flt_fc", frame_count, 6);
      check("flt_src1_tready", ingress_sink_tready[1], 0);
      check("flt_log_n", log_q.size(), 3);
      check("flt_log1", log_q[1], 17'h0C301);
      check("flt_log2", log_q[2], 17'h1C302);
      act[1] = 1'b0;
      apply();
      log_q.delete();

      // watchdog; rr_ptr is 0
      src(0, 4, 16'hD000, 2'd0, 1'b0);
      stall_at[0] = 2;
      src(1, 1, 16'hE100, 2'd0, 1'b0);
      apply();
      step();
      check("wd_grant0", grant_id, 0);
      step();
      step();
      check("wd_silent", egress_source_tvalid, 0);
      for (int c = 0; c < 7; c++) begin
         step();
         check("wd_wait_busy", busy, 1);
         check("wd_wait_tvalid", egress_source_tvalid, 0);
      end
      step();
      check("wd_abort_tvalid", egress_source_tvalid, 1);
      check("wd_abort_tdata", egress_source_tdata, 16'h0000);
      check("wd_abort_tlast", egress_source_tlast, 1);
      check("wd_abort_tready", ingress_sink_tready, 0);
      check("wd_ac_before", abort_count, 0);
      egress_sink_tready = 1'b0;
      #1;
      step();
      check("wd_abort_hold", egress_source_tvalid, 1);
      egress_sink_tready = 1'b1;
      #1;
      step();
      check("wd_ac", abort_count, 1);
      check("wd_idle", busy, 0);
      check("wd_fc", frame_count, 6);
      act[0] = 1'b0;
      apply();
      step();
      check("wd_next_grant", grant_id, 1);
      step();
      check("wd_fc7", frame_count, 7);
      check("wd_log_n", log_q.size(), 4);
      check("wd_log_abort", log_q[2], 17'h10000);

      // enable gating; rr_ptr is 2
      src(2, 3, 16'hF200, 2'd0, 1'b0);
      src(3, 1, 16'hF300, 2'd0, 1'b0);
      apply();
      step();
      check("en_grant2", grant_id, 2);
      en = 1'b0;
      step();
      step();
      step();
      check("en_frame_done", frame_count, 8);
      step();
      step();
      check("en_held_busy", busy, 0);
      check("en_held_grant", grant_id, 2);
      en = 1'b1;
      step();
      check("en_grant3", grant_id, 3);
      check("en_busy", busy, 1);
      step();
      check("en_fc9", frame_count, 9);

      // async reset during beat 2; rr_ptr is 0
      src(0, 4, 16'h1000, 2'd0, 1'b0);
      src(1, 1, 16'h1100, 2'd0, 1'b0);
      apply();
      step();
      check("ar_grant0", grant_id, 0);
      step();
      check("ar_beat2", egress_source_tdata, 16'h1001);
      #2;
      reset = 1'b1;
      #1;
      check("ar_tvalid", egress_source_tvalid, 0);
      check("ar_tready", ingress_sink_tready, 0);
      check("ar_busy", busy, 0);
      check("ar_fc", frame_count, 0);
      check("ar_ac", abort_count, 0);
      check("ar_grant_rst", grant_id, 0);
      step();
      reset = 1'b0;
      step();
      check("ar_regrant", grant_id, 0);
      check("ar_regrant_busy", busy, 1);
      check("ar_resume", egress_source_tdata, 16'h1001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/egress_arbiter.md
# egress_arbiter

Round-robin, frame-atomic arbiter that shares one egress port among `NUM_INGRESS` ingress filter outputs. Each ingress filter drives a tagged stream (`axis_d_source_t`) whose `tdest` selects an egress port. One `egress_arbiter` instance per egress port claims the frames tagged with its `PORT_ID` and forwards them, one whole frame at a time, onto an untagged `axis_source_t` stream. A stall watchdog terminates frames whose source goes silent.

## Interface
- `NUM_INGRESS`, 4: number of requesting ingress filters; 2..8.
- `PORT_ID`, 0: value of `tdest` (2 bits) served by this instance.
- `TIMEOUT_CYCLES`, 64: consecutive idle-source cycles mid-frame before abort; ≥ 2.
- `clk` input, 1: clock.
- `reset` input, 1: asynchronous, active-high reset.
- `en` input, 1: permits new grants; does not affect a frame in progress.
- `ingress_source` input, `NUM_INGRESS` x `axis_d_source_t`: tvalid, tdata[15:0], tdest[1:0], tlast per requester.
- `ingress_sink` output, `NUM_INGRESS` x `axis_d_sink_t`: tready per requester. The top level ORs it with the other arbiters' tready.
- `egress_source` output, `axis_source_t`: tvalid, tdata[15:0], tlast to the port.
- `egress_sink` input, `axis_sink_t`: tready from the port.
- `grant_id` output, $clog2(NUM_INGRESS): index of the current or last granted requester.
- `busy` output, 1: high while in BUSY or ABORT.
- `frame_count` output, 16: frames completed with a source tlast; wraps.
- `abort_count` output, 8: watchdog aborts; saturates at 255.

## Operation
- Request i = `ingress_source[i].tvalid && ingress_source[i].tdest == PORT_ID`.
- State machine:
  - IDLE, when `en` and any request: grant the first requesting index at or after `rr_ptr`, scanning upward modulo `NUM_INGRESS`. Register it in `grant_id`, go to BUSY. Otherwise stay in IDLE.
  - BUSY:
    - `egress_source.tvalid/tdata/tlast` = the granted source's fields.
    - `ingress_sink[grant_id].tready` = `egress_sink.tready`.
    - On a beat with `tvalid && tready && tlast`: increment `frame_count`, set `rr_ptr = grant_id+1` (mod `NUM_INGRESS`), go to IDLE.
    - If the granted tvalid has been low for `TIMEOUT_CYCLES` consecutive BUSY cycles, go to ABORT.
  - ABORT:
    - Drive `egress_source.tvalid=1`, `tdata=16'h0000`, `tlast=1`. All ingress tready are 0.
    - On `egress_sink.tready`: increment `abort_count` (saturating), set `rr_ptr = grant_id+1`, go to IDLE.
- Idle counter: cleared on any granted tvalid high and on entry to BUSY. Counts only in BUSY. Width is $clog2(TIMEOUT_CYCLES+1).
- Non-granted requesters always see tready=0 from this instance. The granted requester's tdest is not re-checked mid-frame.
- A source that resumes after an abort has its remaining beats treated as a new frame on its next grant.
- In IDLE: `egress_source.tvalid=0`, `tlast=0`, `tdata=0`, all tready=0.
- `en` deasserted in BUSY or ABORT: the frame completes normally; no new grant is issued until `en=1`.

## Timing
- Reset (async assert, sync release): state=IDLE, `rr_ptr=0`, `grant_id=0`, `busy=0`, counters 0, idle counter 0. All outputs are 0, including `egress_source.tvalid` and all `ingress_sink.tready`.
- Grant latency: a request seen in IDLE at edge N gives BUSY from edge N+1; the first beat can transfer in cycle N+1.
- In BUSY the data path is combinational (zero latency) from `ingress_source[grant_id]` to `egress_source`, and from `egress_sink.tready` to `ingress_sink[grant_id].tready`.
- Exactly one IDLE bubble cycle between consecutive frames. A single-beat frame occupies 2 cycles minimum.
- A tlast beat handshaken in the same cycle the idle counter would reach `TIMEOUT_CYCLES` cannot occur, since the counter is cleared when tvalid is high. Completion has precedence regardless.
- Abort is entered on the edge where the counter reaches `TIMEOUT_CYCLES`. The termination beat is presented from the next cycle and held until tready.
- `frame_count` and `abort_count` update on the edge following the completing handshake.
- Reset asserted mid-frame: immediate IDLE, outputs 0 without waiting for a clock edge. No termination beat is emitted.

## Test plan
- Single source: source 2 sends a 4-beat frame with tdest=`PORT_ID`, tready=1 → grant_id=2 one cycle after request, 4 beats pass unchanged, tlast on beat 4, `frame_count`=1, `rr_ptr`=3.
- Fairness: all 4 sources hold 2-beat frames continuously from reset → grant order 0,1,2,3,0, one bubble between frames, `frame_count`=5 after 15 cycles.
- Filtering and backpressure: source 1 has tdest≠`PORT_ID`; source 3 has a valid 3-beat frame; egress tready toggles 1,0,1,0 → source 1 never granted and sees tready=0; source 3 beats are held stable during tready=0; no duplicated or lost beats.
- Watchdog: with `TIMEOUT_CYCLES=8`, source 0 sends 2 beats then drops tvalid → after 8 idle cycles a beat with tdata=0, tlast=1 appears; `abort_count`=1; the next grant goes to source 1 if requesting.
- Enable gating: `en` deasserted mid-frame → the frame completes; pending requests are not granted until `en=1`, with grant one cycle later.
- Async reset mid-frame: reset asserted between clock edges during beat 2 → `egress_source.tvalid` and all tready are 0 immediately, counters are 0, and the first grant after release goes to index 0 if requesting.
